// File: rtl/button_debounce_array_pkg.sv
// Shared types and constants for the front-panel button debouncer array.
package button_debounce_array_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      HELD         = 2'b10,
      RELEASE_WAIT = 2'b11
   } state_t;

   localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/button_debounce_array_debounce_channel.sv
// One button channel: tick-qualified debounce FSM with hold timer and registered
// level/press/release/long outputs.
module debounce_channel
   import button_debounce_array_pkg::*;
#(
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned LONG_TICKS     = 64,
   parameter int unsigned CNT_W          = $clog2(LONG_TICKS + 1)
) (
   input  logic i_sys_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   localparam int unsigned DCNT_W = $clog2(DEBOUNCE_TICKS);
   localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [CNT_W-1:0]  LCNT_MAX  = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0]  LCNT_LAST = CNT_W'(LONG_TICKS - 1);

   state_t              r_state, w_state_n;
   logic [DCNT_W-1:0]   r_dcnt,  w_dcnt_n;
   logic [CNT_W-1:0]    r_lcnt,  w_lcnt_n;
   logic                r_level, w_level_n;
   logic                r_press, w_press_n;
   logic                r_release, w_release_n;
   logic                r_long, w_long_n;

   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_dcnt    <= '0;
         r_lcnt    <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_dcnt    <= w_dcnt_n;
         r_lcnt    <= w_lcnt_n;
         r_level   <= w_level_n;
         r_press   <= w_press_n;
         r_release <= w_release_n;
         r_long    <= w_long_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_dcnt_n    = r_dcnt;
      w_lcnt_n    = r_lcnt;
      w_level_n   = r_level;
      w_press_n   = 1'b0;
      w_release_n = 1'b0;
      w_long_n    = 1'b0;
      if (i_tick) begin
         case (r_state)
            IDLE: begin
               if (i_btn) begin
                  w_state_n = PRESS_WAIT;
                  w_dcnt_n  = DCNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!i_btn) begin
                  w_state_n = IDLE;
                  w_dcnt_n  = '0;
               end else if (r_dcnt == DCNT_LAST) begin
                  w_state_n = HELD;
                  w_press_n = 1'b1;
                  w_level_n = 1'b1;
                  w_dcnt_n  = '0;
                  w_lcnt_n  = '0;
               end else begin
                  w_dcnt_n = r_dcnt + DCNT_ONE;
               end
            end
            HELD: begin
               if (!i_btn) begin
                  w_state_n = RELEASE_WAIT;
                  w_dcnt_n  = DCNT_ONE;
               end else if (r_lcnt != LCNT_MAX) begin
                  // saturating at LONG_TICKS guarantees a single long pulse per press
                  w_lcnt_n = r_lcnt + CNT_W'(1);
                  w_long_n = (r_lcnt == LCNT_LAST);
               end
            end
            RELEASE_WAIT: begin
               if (i_btn) begin
                  w_state_n = HELD;
                  w_dcnt_n  = '0;
               end else if (r_dcnt == DCNT_LAST) begin
                  w_state_n   = IDLE;
                  w_release_n = 1'b1;
                  w_level_n   = 1'b0;
                  w_dcnt_n    = '0;
                  w_lcnt_n    = '0;
               end else begin
                  w_dcnt_n = r_dcnt + DCNT_ONE;
               end
            end
            default: w_state_n = IDLE;
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;

endmodule

// File: rtl/button_debounce_array.sv
// N_CH-channel button conditioner: shared slow-clock tick detector, per-button
// synchronisers and one debounce_channel per button.
module button_debounce_array
   import button_debounce_array_pkg::*;
#(
   parameter int unsigned N_CH           = 4,
   parameter int unsigned DEBOUNCE_TICKS = 4,
   parameter int unsigned LONG_TICKS     = 64
) (
   input  logic            fpga_clk,
   input  logic            rst,
   input  logic            i_clk,
   input  logic [N_CH-1:0] button,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release,
   output logic [N_CH-1:0] btn_long
);

   localparam int unsigned CNT_W = $clog2(LONG_TICKS + 1);

   logic [SYNC_STAGES-1:0] r_tick_sync;
   logic                   r_tick_dly;
   logic                   w_tick;
   logic [N_CH-1:0]        r_btn_sync [SYNC_STAGES];
   logic [N_CH-1:0]        w_btn;

   always_ff @(posedge fpga_clk) begin
      if (rst) begin
         r_tick_sync <= '0;
         r_tick_dly  <= 1'b0;
      end else begin
         r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], i_clk};
         r_tick_dly  <= r_tick_sync[SYNC_STAGES-1];
      end
   end

   // rising edge of the synchronised slow clock, one fpga_clk cycle wide
   assign w_tick = r_tick_sync[SYNC_STAGES-1] & ~r_tick_dly;

   always_ff @(posedge fpga_clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            r_btn_sync[s] <= '0;
         end
      end else begin
         r_btn_sync[0] <= button;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            r_btn_sync[s] <= r_btn_sync[s-1];
         end
      end
   end

   assign w_btn = r_btn_sync[SYNC_STAGES-1];

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
         .LONG_TICKS    (LONG_TICKS),
         .CNT_W         (CNT_W)
      ) u_ch (
         .i_sys_clk(fpga_clk),
         .i_rst    (rst),
         .i_tick   (w_tick),
         .i_btn    (w_btn[g]),
         .o_level  (btn_level[g]),
         .o_press  (btn_press[g]),
         .o_release(btn_release[g]),
         .o_long   (btn_long[g])
      );
   end

endmodule
